regfile_writeback: RTL

//  Write-side driver for RegisterFile. Collects results from ALU and LSU through

---
 rtl/regfile_writeback_pkg.sv | 21 ++
 rtl/regfile_writeback_if.sv | 27 ++
 rtl/regfile_writeback_fifo.sv | 67 ++++++
 rtl/regfile_writeback.sv | 104 ++++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared widths, source identifiers and helpers for the register-file writeback path.
package regfile_writeback_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_DEPTH   = 2;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask     = '0;
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Result handshakes from the ALU and LSU into the writeback block.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN = regfile_writeback_pkg::XLEN
);

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready
  );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Small synchronous FIFO of {rd, data} results; also reports which destinations it holds.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN  = regfile_writeback_pkg::XLEN,
  parameter int DEPTH = WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  output logic [REG_ADDR_W-1:0] head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [NUM_REGS-1:0]   rd_mask
);

  logic [REG_ADDR_W-1:0] mem_rd   [DEPTH];
  logic [XLEN-1:0]       mem_data [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      offset;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign empty     = (count == '0);

  // Slot i is live when its distance from the read pointer is below the fill level.
  always_comb begin
    rd_mask = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr;
      if ({1'b0, offset} < count) rd_mask = rd_mask | rd_onehot(mem_rd[i]);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Buffers ALU and LSU results, arbitrates round-robin between them, and drives the
// RegisterFile write port one result per cycle.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN  = regfile_writeback_pkg::XLEN,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_writeback_if.slave    src,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [XLEN-1:0]       write_data,
  output logic                  write_enable,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [31:0]           retired_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_ready, lsu_ready;
  logic                  alu_push, lsu_push;
  logic                  alu_pop, lsu_pop;
  logic                  alu_empty, lsu_empty;
  logic [CNT_W-1:0]      alu_count, lsu_count;
  logic [REG_ADDR_W-1:0] alu_head_rd, lsu_head_rd;
  logic [XLEN-1:0]       alu_head_data, lsu_head_data;
  logic [NUM_REGS-1:0]   alu_mask, lsu_mask;
  wb_src_e               last_grant;

  // Ready depends only on fill level and reset, so a full FIFO stays closed even while popping.
  assign alu_ready     = rst_n && (alu_count != CNT_W'(DEPTH));
  assign lsu_ready     = rst_n && (lsu_count != CNT_W'(DEPTH));
  assign src.alu_ready = alu_ready;
  assign src.lsu_ready = lsu_ready;
  assign alu_push      = src.alu_valid && alu_ready;
  assign lsu_push      = src.lsu_valid && lsu_ready;

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .push_rd   (src.alu_rd),
    .push_data (src.alu_data),
    .pop       (alu_pop),
    .head_rd   (alu_head_rd),
    .head_data (alu_head_data),
    .empty     (alu_empty),
    .count     (alu_count),
    .rd_mask   (alu_mask)
  );

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_push),
    .push_rd   (src.lsu_rd),
    .push_data (src.lsu_data),
    .pop       (lsu_pop),
    .head_rd   (lsu_head_rd),
    .head_data (lsu_head_data),
    .empty     (lsu_empty),
    .count     (lsu_count),
    .rd_mask   (lsu_mask)
  );

  // On a tie the source that did not win last time goes first.
  always_comb begin
    alu_pop = 1'b0;
    lsu_pop = 1'b0;
    if (!alu_empty && !lsu_empty) begin
      if (last_grant == WB_ALU) lsu_pop = 1'b1;
      else                      alu_pop = 1'b1;
    end else if (!alu_empty) begin
      alu_pop = 1'b1;
    end else if (!lsu_empty) begin
      lsu_pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_address <= '0;
      write_data    <= '0;
      write_enable  <= 1'b0;
      retired_count <= '0;
      last_grant    <= WB_ALU;
    end else if (alu_pop || lsu_pop) begin
      write_address <= lsu_pop ? lsu_head_rd : alu_head_rd;
      write_data    <= lsu_pop ? lsu_head_data : alu_head_data;
      write_enable  <= (lsu_pop ? lsu_head_rd : alu_head_rd) != '0;
      last_grant    <= lsu_pop ? WB_LSU : WB_ALU;
      retired_count <= retired_count + 32'd1;
    end else begin
      write_enable  <= 1'b0;
    end
  end

  // x0 never has a real write in flight, so its bit is forced low.
  assign pending_mask = (alu_mask | lsu_mask |
                         (write_enable ? rd_onehot(write_address) : '0)) &
                        ~NUM_REGS'(1);

endmodule
